// File: rtl/dsm_dem_pkg.sv
// Shared defaults and width helpers for the DSM-to-DEM routing slice.
package dsm_dem_pkg;

  localparam int DEF_NCH    = 2;
  localparam int DEF_SPC    = 2;
  localparam int DEF_QW     = 5;
  localparam int DEF_OFFSET = 8;

  // ceil(log2(n)), never narrower than one bit
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // width of a channel index
  function automatic int chw_of(input int nch);
    return clog2_min1(nch);
  endfunction

  // width of a frame slot index
  function automatic int sw_of(input int frame);
    return clog2_min1(frame);
  endfunction

endpackage

// File: rtl/dsm_code_conv.sv
// Two's-complement quantizer code to offset-binary DEM code, with per-output mute.
// A muted output parks at OFFSET, the mid-scale DEM code.
module dsm_code_conv #(
  parameter int QW     = 5,
  parameter int OFFSET = 8
) (
  input  logic [QW-1:0] code,
  input  logic          mute,
  output logic [QW-1:0] dem_code
);

  // the add wraps modulo 2^QW by construction
  assign dem_code = mute ? QW'(OFFSET) : code + QW'(OFFSET);

endmodule

// File: rtl/dsm_dem_router.sv
// Routes time-multiplexed quantizer samples to per-channel DEM inputs once per frame.
// A slot counter walks the frame; samples are staged per channel and the whole
// output vector, through a frame-latched channel map, updates on the last slot.
module dsm_dem_router
  import dsm_dem_pkg::*;
#(
  parameter  int NCH    = DEF_NCH,
  parameter  int SPC    = DEF_SPC,
  parameter  int QW     = DEF_QW,
  parameter  int OFFSET = DEF_OFFSET,
  localparam int FRAME  = NCH * SPC,
  localparam int CHW    = chw_of(NCH),
  localparam int SW     = sw_of(FRAME)
) (
  input  logic               mclk512,
  input  logic               reset_n,
  input  logic               enable,
  output logic [SW-1:0]      slot_cnt,
  output logic [CHW-1:0]     chan_sel,
  output logic               frame_end,
  input  logic [QW-1:0]      q_data,
  input  logic               q_valid,
  input  logic [CHW-1:0]     q_chan,
  input  logic [NCH*CHW-1:0] map_in,
  input  logic [NCH-1:0]     mute,
  input  logic               sticky_clr,
  output logic [NCH*QW-1:0]  dem_in,
  output logic               dem_valid,
  output logic [NCH-1:0]     miss_sticky,
  output logic               ovfl_sticky
);

  function automatic logic [NCH*CHW-1:0] identity_map();
    logic [NCH*CHW-1:0] m;
    m = '0;
    for (int k = 0; k < NCH; k++) m[k*CHW +: CHW] = CHW'(k);
    return m;
  endfunction

  function automatic logic [NCH*QW-1:0] mid_scale();
    logic [NCH*QW-1:0] d;
    d = '0;
    for (int k = 0; k < NCH; k++) d[k*QW +: QW] = QW'(OFFSET);
    return d;
  endfunction

  localparam logic [NCH*CHW-1:0] MAP_ID  = identity_map();
  localparam logic [NCH*QW-1:0]  DEM_MID = mid_scale();

  logic [SW-1:0]      slot_q;
  logic [QW-1:0]      stage_q   [NCH];
  logic [QW-1:0]      stage_now [NCH];
  logic [QW-1:0]      sel_code  [NCH];
  logic [QW-1:0]      conv_code [NCH];
  logic [NCH-1:0]     stvalid_q;
  logic [NCH-1:0]     stvalid_now;
  logic [NCH*CHW-1:0] map_q;
  logic [NCH*CHW-1:0] map_nxt;
  logic [NCH*QW-1:0]  dem_q;
  logic [NCH*QW-1:0]  dem_nxt;
  logic               dv_q;
  logic [NCH-1:0]     miss_q;
  logic               ovfl_q;
  logic               last_slot;
  logic               chan_ok;
  logic               wr_en;

  assign last_slot = (slot_q == SW'(FRAME - 1));
  assign frame_end = enable & last_slot;
  assign slot_cnt  = slot_q;
  assign chan_sel  = CHW'(32'(slot_q) / 32'(SPC));

  assign chan_ok = (32'(q_chan) < 32'(NCH));
  assign wr_en   = enable & q_valid & chan_ok;

  // the map is only ever consumed on the frame_end edge, where the fresh value applies
  assign map_nxt = frame_end ? map_in : map_q;

  // stage contents including this cycle's sample; unwritten channels hold
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      stage_now[c]   = (wr_en && (q_chan == CHW'(c))) ? q_data : stage_q[c];
      stvalid_now[c] = stvalid_q[c] | (wr_en && (q_chan == CHW'(c)));
    end
  end

  // pick each output's source channel; a map entry beyond NCH-1 falls back to channel 0
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sel_code[k] = stage_now[0];
      for (int c = 1; c < NCH; c++) begin
        if (map_nxt[k*CHW +: CHW] == CHW'(c)) sel_code[k] = stage_now[c];
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_conv
    dsm_code_conv #(.QW(QW), .OFFSET(OFFSET)) u_conv (
      .code     (sel_code[k]),
      .mute     (mute[k]),
      .dem_code (conv_code[k])
    );
  end

  // pack the converted codes into the DEM bus layout
  always_comb begin
    dem_nxt = '0;
    for (int k = 0; k < NCH; k++) dem_nxt[k*QW +: QW] = conv_code[k];
  end

  // sequencer, staging, map shadow, output register and sticky flags
  always_ff @(posedge mclk512) begin
    if (!reset_n) begin
      slot_q    <= '0;
      stvalid_q <= '0;
      map_q     <= MAP_ID;
      dem_q     <= DEM_MID;
      dv_q      <= 1'b0;
      miss_q    <= '0;
      ovfl_q    <= 1'b0;
      for (int c = 0; c < NCH; c++) stage_q[c] <= '0;
    end else begin
      slot_q    <= (!enable || last_slot) ? '0 : slot_q + SW'(1);
      for (int c = 0; c < NCH; c++) stage_q[c] <= stage_now[c];
      stvalid_q <= (!enable || frame_end) ? '0 : stvalid_now;
      map_q     <= map_nxt;
      dv_q      <= frame_end;
      if (frame_end) dem_q <= dem_nxt;
      miss_q    <= (sticky_clr ? '0 : miss_q) | (frame_end ? ~stvalid_now : '0);
      ovfl_q    <= (sticky_clr ? 1'b0 : ovfl_q) | (q_valid & ~chan_ok);
    end
  end

  assign dem_in      = dem_q;
  assign dem_valid   = dv_q;
  assign miss_sticky = miss_q;
  assign ovfl_sticky = ovfl_q;

endmodule

// File: tb/tb_dsm_dem_router.sv
// Bench for dsm_dem_router: default instance (NCH=2, SPC=2) driven by a vector
// table, hand sequences and random stimulus against a frame-level model; a second
// instance (NCH=3, SPC=1) covers overflow tagging and mute.
module tb_dsm_dem_router;

  localparam int A_FRAME = 4;
  localparam int OFS     = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       a_rst, a_en, a_qv, a_clr;
  logic [0:0] a_qc;
  logic [4:0] a_qd;
  logic [1:0] a_map, a_mute;
  logic [1:0] a_slot;
  logic [0:0] a_chan;
  logic       a_fe, a_dv, a_ovfl;
  logic [9:0] a_dem;
  logic [1:0] a_miss;

  dsm_dem_router u_a (
    .mclk512(clk), .reset_n(a_rst), .enable(a_en),
    .slot_cnt(a_slot), .chan_sel(a_chan), .frame_end(a_fe),
    .q_data(a_qd), .q_valid(a_qv), .q_chan(a_qc),
    .map_in(a_map), .mute(a_mute), .sticky_clr(a_clr),
    .dem_in(a_dem), .dem_valid(a_dv), .miss_sticky(a_miss), .ovfl_sticky(a_ovfl)
  );

  // three-channel, one-slot instance
  logic        b_rst, b_en, b_qv, b_clr;
  logic [1:0]  b_qc;
  logic [4:0]  b_qd;
  logic [5:0]  b_map;
  logic [2:0]  b_mute;
  logic [1:0]  b_slot, b_chan;
  logic        b_fe, b_dv, b_ovfl;
  logic [14:0] b_dem;
  logic [2:0]  b_miss;

  dsm_dem_router #(.NCH(3), .SPC(1)) u_b (
    .mclk512(clk), .reset_n(b_rst), .enable(b_en),
    .slot_cnt(b_slot), .chan_sel(b_chan), .frame_end(b_fe),
    .q_data(b_qd), .q_valid(b_qv), .q_chan(b_qc),
    .map_in(b_map), .mute(b_mute), .sticky_clr(b_clr),
    .dem_in(b_dem), .dem_valid(b_dv), .miss_sticky(b_miss), .ovfl_sticky(b_ovfl)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // frame-level reference model of the default instance
  int m_slot;
  int m_st   [2];
  bit m_got  [2];
  int m_out  [2];
  bit m_dv;
  logic [1:0] m_miss;
  bit m_ovfl;

  task automatic model_step();
    bit fe;
    logic [1:0] nmiss;
    if (!a_rst) begin
      m_slot = 0; m_dv = 0; m_miss = 0; m_ovfl = 0;
      for (int c = 0; c < 2; c++) begin
        m_st[c] = 0; m_got[c] = 0; m_out[c] = OFS;
      end
    end else begin
      fe    = a_en && (m_slot == A_FRAME - 1);
      nmiss = 2'b00;
      if (a_en && a_qv) begin
        m_st[a_qc]  = int'(a_qd);
        m_got[a_qc] = 1;
      end
      if (fe) begin
        for (int k = 0; k < 2; k++)
          m_out[k] = a_mute[k] ? OFS : (m_st[a_map[k]] + OFS) % 32;
        for (int c = 0; c < 2; c++) begin
          nmiss[c] = !m_got[c];
          m_got[c] = 0;
        end
      end
      m_dv = fe;
      if (a_clr) begin
        m_miss = 2'b00;
        m_ovfl = 0;
      end
      m_miss = m_miss | nmiss;
      if (!a_en) begin
        m_got[0] = 0;
        m_got[1] = 0;
      end
      m_slot = a_en ? (m_slot + 1) % A_FRAME : 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_slot"}, a_slot, m_slot);
    chk({tag, "_chan_sel"}, a_chan, m_slot / 2);
    chk({tag, "_frame_end"}, a_fe, (a_en && m_slot == A_FRAME - 1));
    chk({tag, "_dem_valid"}, a_dv, m_dv);
    chk({tag, "_dem_in"}, a_dem, (m_out[1] << 5) | m_out[0]);
    chk({tag, "_miss"}, a_miss, m_miss);
    chk({tag, "_ovfl"}, a_ovfl, m_ovfl);
  endtask

  function automatic logic [9:0] d2(input int o1, input int o0);
    return 10'((o1 << 5) | o0);
  endfunction

  typedef struct {
    logic       qv;
    logic       qc;
    logic [4:0] qd;
    logic [1:0] map;
    logic       clr;
    logic [1:0] e_slot;
    logic       e_dv;
    logic [9:0] e_dem;
    logic [1:0] e_miss;
  } vec_t;

  vec_t tab [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    // enable=1, mute=0 throughout; map 2'b10 = identity, 2'b01 = swapped
    tab[0]  = '{1'b0, 1'b0, 5'd0,     2'b10, 1'b0, 2'd1, 1'b0, d2(8, 8),   2'b00};
    tab[1]  = '{1'b1, 1'b0, 5'b11101, 2'b10, 1'b0, 2'd2, 1'b0, d2(8, 8),   2'b00};
    tab[2]  = '{1'b0, 1'b0, 5'd0,     2'b10, 1'b0, 2'd3, 1'b0, d2(8, 8),   2'b00};
    tab[3]  = '{1'b1, 1'b1, 5'b00111, 2'b10, 1'b0, 2'd0, 1'b1, d2(15, 5),  2'b00};
    tab[4]  = '{1'b0, 1'b0, 5'd0,     2'b10, 1'b0, 2'd1, 1'b0, d2(15, 5),  2'b00};
    tab[5]  = '{1'b1, 1'b0, 5'd1,     2'b01, 1'b0, 2'd2, 1'b0, d2(15, 5),  2'b00};
    tab[6]  = '{1'b1, 1'b1, 5'd2,     2'b01, 1'b0, 2'd3, 1'b0, d2(15, 5),  2'b00};
    tab[7]  = '{1'b0, 1'b0, 5'd0,     2'b01, 1'b0, 2'd0, 1'b1, d2(9, 10),  2'b00};
    tab[8]  = '{1'b1, 1'b0, 5'd3,     2'b10, 1'b0, 2'd1, 1'b0, d2(9, 10),  2'b00};
    tab[9]  = '{1'b0, 1'b0, 5'd0,     2'b10, 1'b0, 2'd2, 1'b0, d2(9, 10),  2'b00};
    tab[10] = '{1'b0, 1'b0, 5'd0,     2'b10, 1'b0, 2'd3, 1'b0, d2(9, 10),  2'b00};
    tab[11] = '{1'b0, 1'b0, 5'd0,     2'b10, 1'b0, 2'd0, 1'b1, d2(10, 11), 2'b10};
    tab[12] = '{1'b1, 1'b0, 5'd4,     2'b10, 1'b1, 2'd1, 1'b0, d2(10, 11), 2'b00};
    tab[13] = '{1'b0, 1'b0, 5'd0,     2'b10, 1'b0, 2'd2, 1'b0, d2(10, 11), 2'b00};
    tab[14] = '{1'b0, 1'b0, 5'd0,     2'b10, 1'b0, 2'd3, 1'b0, d2(10, 11), 2'b00};
    tab[15] = '{1'b0, 1'b0, 5'd0,     2'b10, 1'b1, 2'd0, 1'b1, d2(10, 12), 2'b10};

    a_rst = 0; a_en = 0; a_qv = 0; a_qc = 0; a_qd = 0; a_map = 2'b10; a_mute = 0; a_clr = 0;
    b_rst = 0; b_en = 0; b_qv = 0; b_qc = 0; b_qd = 0; b_map = 6'b100100; b_mute = 0; b_clr = 0;

    step();
    step();
    chk("rst_slot", a_slot, 0);
    chk("rst_dem_in", a_dem, d2(8, 8));
    chk("rst_dem_valid", a_dv, 0);
    chk("rst_miss", a_miss, 0);
    chk("rst_ovfl", a_ovfl, 0);

    // table: conversion, map swap latched at frame end, miss hold, sticky clear
    a_rst = 1; a_en = 1;
    for (int i = 0; i < 16; i++) begin
      a_qv = tab[i].qv; a_qc = tab[i].qc; a_qd = tab[i].qd;
      a_map = tab[i].map; a_clr = tab[i].clr;
      step();
      chk($sformatf("tab%0d_slot", i), a_slot, tab[i].e_slot);
      chk($sformatf("tab%0d_dem_valid", i), a_dv, tab[i].e_dv);
      chk($sformatf("tab%0d_dem_in", i), a_dem, tab[i].e_dem);
      chk($sformatf("tab%0d_miss", i), a_miss, tab[i].e_miss);
    end
    a_qv = 0; a_clr = 0; a_map = 2'b10;

    // enable dropped mid-frame: no dem_valid, counter parks at 0
    step(); step();
    a_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_model($sformatf("en_off%0d", i));
      chk("en_off_no_valid", a_dv, 0);
    end
    a_en = 1;
    step(); step(); step();
    // sample arriving in the frame_end cycle lands in this frame's output
    a_qv = 1; a_qc = 1; a_qd = 5'd9;
    step();
    chk_model("fe_sample");
    chk("fe_sample_dv", a_dv, 1);
    chk("fe_sample_out1", a_dem[9:5], 17);
    a_qv = 0;

    // reset at slot 2, then count edges (reset edge included) to the first dem_valid
    step(); step();
    a_rst = 0;
    step();
    chk("midrst_dem_in", a_dem, d2(8, 8));
    chk("midrst_slot", a_slot, 0);
    chk("midrst_miss", a_miss, 0);
    a_rst = 1;
    lat = 99;
    for (int n = 2; n <= 12; n++) begin
      step();
      chk_model($sformatf("postrst%0d", n));
      if (a_dv) begin
        lat = n;
        break;
      end
    end
    chk("postrst_latency", lat, A_FRAME + 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      a_rst  = ($urandom_range(0, 63) != 0);
      a_en   = ($urandom_range(0, 15) != 0);
      a_qv   = 1'($urandom);
      a_qc   = 1'($urandom);
      a_qd   = 5'($urandom);
      a_map  = 2'($urandom);
      a_mute = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      a_clr  = ($urandom_range(0, 7) == 0);
      step();
      chk_model($sformatf("rnd%0d", i));
    end
    a_en = 0; a_qv = 0; a_clr = 0; a_mute = 0;

    // three-channel instance: overflow tag discarded, mute parks output at OFFSET
    @(posedge clk); #1;
    chk("b_rst_dem_in", b_dem, 15'((8 << 10) | (8 << 5) | 8));
    chk("b_rst_ovfl", b_ovfl, 0);
    b_rst = 1; b_en = 1;
    b_qv = 1; b_qc = 2'd3; b_qd = 5'd31;
    @(posedge clk); #1;
    chk("b_ovfl_set", b_ovfl, 1);
    chk("b_ovfl_no_out_change", b_dem, 15'((8 << 10) | (8 << 5) | 8));
    chk("b_slot1", b_slot, 1);
    b_qc = 2'd0; b_qd = 5'd1;
    @(posedge clk); #1;
    chk("b_chan_sel2", b_chan, 2);
    b_qc = 2'd2; b_qd = 5'd2; b_mute = 3'b010;
    @(posedge clk); #1;
    chk("b_fe_dv", b_dv, 1);
    chk("b_mute_dem_in", b_dem, 15'((10 << 10) | (8 << 5) | 9));
    chk("b_miss", b_miss, 3'b010);
    chk("b_ovfl_hold", b_ovfl, 1);
    chk("b_slot_wrap", b_slot, 0);
    b_mute = 0; b_clr = 1; b_qc = 2'd1; b_qd = 5'd3;
    @(posedge clk); #1;
    chk("b_clr_ovfl", b_ovfl, 0);
    chk("b_clr_miss", b_miss, 0);
    b_clr = 0; b_qc = 2'd0; b_qd = 5'd0;
    @(posedge clk); #1;
    b_qc = 2'd2; b_qd = 5'd5;
    @(posedge clk); #1;
    chk("b_frame2_dem_in", b_dem, 15'((13 << 10) | (11 << 5) | 8));
    chk("b_frame2_miss", b_miss, 0);
    b_qv = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
